// File: rtl/register_write_decoder.sv
// register_write_decoder
//   Write side of the ARM register file: decodes the destination register
//   number into a one-hot strobe, holds R0..R15 in flops, provides a
//   dedicated PC (R15) load path, and tracks which registers were written
//   through the write port since the last clear.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous, active-low reset
//   wr_en        write-port enable
//   wr_addr      destination register number
//   wr_data      write-port data
//   pc_ld        PC update enable (fetch/branch path)
//   pc_data      next PC value
//   clr_written  synchronous clear of the written bitmap
//   dec_out      one-hot write strobe, bit i = write to Ri
//   regs_flat    Ri on bits [DATA_W*i +: DATA_W]
//   written      bit i = Ri written via the write port since clear/reset
module register_write_decoder #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 4,
  parameter int                PC_IDX   = 15,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           pc_ld,
  input  logic [DATA_W-1:0]              pc_data,
  input  logic                           clr_written,
  output logic [(1<<ADDR_W)-1:0]         dec_out,
  output logic [DATA_W*(1<<ADDR_W)-1:0]  regs_flat,
  output logic [(1<<ADDR_W)-1:0]         written
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  // Decoder. An unknown wr_addr makes every comparison false in simulation,
  // so no strobe is raised and nothing gets written.
  always_comb begin
    dec_out = '0;
    if (wr_en && rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_addr == ADDR_W'(i)) dec_out[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == PC_IDX) ? PC_RESET : '0;
      end
      written <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (dec_out[i]) regs[i] <= wr_data;
      end
      // An explicit write to the PC through the write port overrides the
      // sequential fetch update in the same cycle.
      if (pc_ld && !dec_out[PC_IDX]) regs[PC_IDX] <= pc_data;
      // Clear takes effect before the set of the same cycle.
      written <= clr_written ? dec_out : (written | dec_out);
    end
  end

  // Read ports see the flops directly; no write-to-read bypass.
  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[DATA_W*g +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_register_write_decoder.sv
module tb_register_write_decoder;

  localparam logic [31:0] PC_RST = 32'h0000_0040;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         pc_ld;
  logic [31:0]  pc_data;
  logic         clr_written;
  logic [15:0]  dec_out;
  logic [511:0] regs_flat;
  logic [15:0]  written;

  int checks = 0;
  int errors = 0;

  register_write_decoder #(
    .DATA_W(32), .ADDR_W(4), .PC_IDX(15), .PC_RESET(PC_RST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pc_ld(pc_ld), .pc_data(pc_data),
    .clr_written(clr_written), .dec_out(dec_out),
    .regs_flat(regs_flat), .written(written)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] reg_val(input int i);
    return regs_flat[32*i +: 32];
  endfunction

  task automatic test_reset();
    logic [31:0] exp;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pc_ld = 1'b0; pc_data = '0; clr_written = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? PC_RST : 32'h0;
      checks++;
      if (reg_val(i) !== exp) begin
        errors++; $display("FAIL reset_init_r%0d got %h want %h", i, reg_val(i), exp);
      end
    end
    checks++;
    if (written !== 16'h0) begin errors++; $display("FAIL reset_init_written got %h want 0000", written); end
    // Write requested while in reset: strobe must stay low.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (dec_out !== 16'h0) begin errors++; $display("FAIL reset_dec_held got %h want 0000", dec_out); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (dec_out !== 16'h0008) begin errors++; $display("FAIL reset_dec_release got %h want 0008", dec_out); end
    @(posedge clk); #1;
    checks++;
    if (reg_val(3) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_pre_r3 got %h want deadbeef", reg_val(3)); end
    checks++;
    if (written !== 16'h0008) begin errors++; $display("FAIL reset_pre_written got %h want 0008", written); end
    // Assert reset mid-cycle with a write still in flight.
    @(negedge clk);
    wr_data = 32'h1234_5678;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? PC_RST : 32'h0;
      checks++;
      if (reg_val(i) !== exp) begin
        errors++; $display("FAIL reset_async_r%0d got %h want %h", i, reg_val(i), exp);
      end
    end
    checks++;
    if (written !== 16'h0) begin errors++; $display("FAIL reset_async_written got %h want 0000", written); end
    checks++;
    if (dec_out !== 16'h0) begin errors++; $display("FAIL reset_async_dec got %h want 0000", dec_out); end
    @(posedge clk); #1;
    checks++;
    if (reg_val(3) !== 32'h0) begin errors++; $display("FAIL reset_discard_r3 got %h want 0", reg_val(3)); end
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_decode_sweep();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 32'h1000_0000 + 32'(i);
      #1;
      checks++;
      if (dec_out !== (16'h1 << i)) begin
        errors++; $display("FAIL sweep_dec_%0d got %h want %h", i, dec_out, 16'h1 << i);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (reg_val(i) !== 32'h1000_0000 + 32'(i)) begin
        errors++; $display("FAIL sweep_r%0d got %h want %h", i, reg_val(i), 32'h1000_0000 + 32'(i));
      end
    end
    checks++;
    if (written !== 16'hFFFF) begin errors++; $display("FAIL sweep_written got %h want ffff", written); end
  endtask

  task automatic test_pc_path();
    @(negedge clk);
    clr_written = 1'b1;
    @(negedge clk);
    clr_written = 1'b0;
    checks++;
    if (written !== 16'h0) begin errors++; $display("FAIL pc_clear got %h want 0000", written); end
    pc_ld = 1'b1; pc_data = 32'h0000_0004;
    #1;
    checks++;
    if (dec_out !== 16'h0) begin errors++; $display("FAIL pc_dec got %h want 0000", dec_out); end
    checks++;
    if (reg_val(15) !== 32'h1000_000F) begin errors++; $display("FAIL pc_before got %h want 1000000f", reg_val(15)); end
    @(posedge clk); #1;
    checks++;
    if (reg_val(15) !== 32'h0000_0004) begin errors++; $display("FAIL pc_first got %h want 00000004", reg_val(15)); end
    @(negedge clk);
    pc_data = 32'h0000_0008;
    @(posedge clk); #1;
    checks++;
    if (reg_val(15) !== 32'h0000_0008) begin errors++; $display("FAIL pc_second got %h want 00000008", reg_val(15)); end
    checks++;
    if (written[15] !== 1'b0) begin errors++; $display("FAIL pc_written15 got %b want 0", written[15]); end
    checks++;
    if (reg_val(14) !== 32'h1000_000E) begin errors++; $display("FAIL pc_r14_hold got %h want 1000000e", reg_val(14)); end
    @(negedge clk);
    pc_ld = 1'b0;
  endtask

  task automatic test_collision();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h0000_0100;
    pc_ld = 1'b1; pc_data = 32'h0000_0010;
    @(posedge clk); #1;
    checks++;
    if (reg_val(15) !== 32'h0000_0100) begin errors++; $display("FAIL collision_r15 got %h want 00000100", reg_val(15)); end
    checks++;
    if (written !== 16'h8000) begin errors++; $display("FAIL collision_written got %h want 8000", written); end
    @(negedge clk);
    wr_en = 1'b0; pc_ld = 1'b0;
  endtask

  task automatic test_bitmap_clear();
    @(negedge clk);
    clr_written = 1'b1;
    @(negedge clk);
    clr_written = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h0000_0022;
    @(negedge clk);
    wr_addr = 4'd7; wr_data = 32'h0000_0077;
    @(negedge clk);
    checks++;
    if (written !== 16'h0084) begin errors++; $display("FAIL clr_pre_written got %h want 0084", written); end
    clr_written = 1'b1; wr_addr = 4'd5; wr_data = 32'h0000_0055;
    @(posedge clk); #1;
    checks++;
    if (written !== 16'h0020) begin errors++; $display("FAIL clr_written got %h want 0020", written); end
    checks++;
    if (reg_val(2) !== 32'h0000_0022) begin errors++; $display("FAIL clr_r2 got %h want 00000022", reg_val(2)); end
    checks++;
    if (reg_val(7) !== 32'h0000_0077) begin errors++; $display("FAIL clr_r7 got %h want 00000077", reg_val(7)); end
    checks++;
    if (reg_val(5) !== 32'h0000_0055) begin errors++; $display("FAIL clr_r5 got %h want 00000055", reg_val(5)); end
    @(negedge clk);
    clr_written = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_disabled();
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 4'd4; wr_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (dec_out !== 16'h0) begin errors++; $display("FAIL dis_dec got %h want 0000", dec_out); end
    @(posedge clk); #1;
    checks++;
    if (reg_val(4) !== 32'h1000_0004) begin errors++; $display("FAIL dis_r4 got %h want 10000004", reg_val(4)); end
    checks++;
    if (written !== 16'h0020) begin errors++; $display("FAIL dis_written got %h want 0020", written); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'hAAAA_0001; vals[1] = 32'hBBBB_0002; vals[2] = 32'hCCCC_0003;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = vals[k];
      @(posedge clk); #1;
      checks++;
      if (reg_val(9) !== vals[k]) begin errors++; $display("FAIL b2b_r9_%0d got %h want %h", k, reg_val(9), vals[k]); end
    end
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (reg_val(9) !== 32'hCCCC_0003) begin errors++; $display("FAIL b2b_final got %h want cccc0003", reg_val(9)); end
    checks++;
    if (reg_val(0) !== 32'h1000_0000) begin errors++; $display("FAIL b2b_r0 got %h want 10000000", reg_val(0)); end
    checks++;
    if (written !== 16'h0220) begin errors++; $display("FAIL b2b_written got %h want 0220", written); end
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_pc_path();
    test_collision();
    test_bitmap_clear();
    test_disabled();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_write_decoder.md
Name: register_write_decoder

Overview:
Write side of the 16-entry, 32-bit ARM register file. It decodes a 4-bit destination register number into a one-hot write strobe and holds registers R0-R15 in flops. All sixteen register values are exported flat to the 16-to-1 read-port multiplexers. It has a dedicated PC (R15) load path and a per-register "written since clear" bitmap for hazard and debug logic.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register-number width; NREGS = 2**ADDR_W = 16
PC_IDX, 15, index of the program counter register
PC_RESET, 32'h0000_0000, value loaded into R15 on reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
wr_en  input  1  write-port enable
wr_addr  input  4  destination register number
wr_data  input  32  write-port data
pc_ld  input  1  PC update enable (fetch/branch path)
pc_data  input  32  next PC value
clr_written  input  1  synchronous clear of the written bitmap
dec_out  output  16  one-hot decoded write strobe, bit i = write to Ri
regs_flat  output  512  Ri on bits [32*i+31 : 32*i]; R0 occupies [31:0]
written  output  16  bit i = Ri written through the write port since the last clear or reset

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous deassert at the board level):
  - R0-R14 = 0; R15 = PC_RESET; written = 16'h0000.
  - dec_out is forced to 0 while rst_n=0.
  - Any write in flight when reset asserts is discarded.
- Decoder, combinational:
  - dec_out = (wr_en && rst_n) ? (1 << wr_addr) : 0.
  - Exactly one bit is set when enabled; otherwise all bits are 0.
  - If wr_addr contains X/Z, dec_out = 0 and no register is written.
- Register update, on the rising edge of clk with rst_n=1:
  - For each i, if dec_out[i], Ri <= wr_data.
  - If pc_ld, R15 <= pc_data.
  - Collision (wr_en && wr_addr==PC_IDX && pc_ld): the write port wins. R15 <= wr_data and pc_data is dropped. This lets branches via explicit R15 writes override sequential fetch.
  - Registers not addressed hold their value.
- Latency:
  - regs_flat is driven directly from the flops.
  - A value written at edge N is visible on regs_flat immediately after edge N, i.e. one cycle after wr_en is presented.
  - There is no internal write-to-read bypass. Forwarding within the same cycle belongs to the pipeline.
- Written bitmap, updated on the clock edge:
  - A write-port write sets written[wr_addr].
  - pc_ld does not set written[15].
  - clr_written clears all bits.
  - When clr_written and wr_en occur in the same cycle, the clear is applied first, then the set. Result: written = dec_out.
- No R0-is-zero rule. R0 is an ordinary register.
- Consecutive writes to the same register on back-to-back cycles are all accepted. The last one wins.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle after writing R3=32'hDEAD_BEEF -> regs_flat immediately shows all R0-R14=0, R15=PC_RESET, written=0, dec_out=0.
- Decode sweep: wr_en=1, wr_addr=0..15 with wr_data=32'h1000_0000+i -> dec_out=1<<i each cycle; afterward Ri=32'h1000_0000+i for all i; written=16'hFFFF.
- PC path: pc_ld=1, pc_data=32'h0000_0004 then 32'h0000_0008 -> R15 follows one edge later; written[15] stays 0; dec_out=0.
- Collision: same cycle wr_en=1, wr_addr=15, wr_data=32'h0000_0100, pc_ld=1, pc_data=32'h0000_0010 -> R15=32'h0000_0100; written[15]=1.
- Bitmap clear: after writing R2 and R7 (written=16'h0084), assert clr_written with wr_en to R5 in the same cycle -> written=16'h0020; R2 and R7 data retained.
- Disabled write: wr_en=0 with wr_addr=4, wr_data=32'hFFFF_FFFF -> dec_out=0; R4 and written unchanged.
